// File: rtl/modbus_frame_tx_ctrl.sv
// Modbus RTU frame transmit sequencer: reads a frame byte-by-byte from a buffer,
// drives a UART byte transmitter, then holds the line silent for t3.5 before completing.
module modbus_frame_tx_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int GAP_CYCLES     = 87500,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_start_i,
  input  logic [ADDR_W-1:0] frame_len_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              frame_err_o
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_TX, GAP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic last_byte, to_hit, gap_hit;

  assign last_byte = (idx_q == (len_q - 1'b1));
  assign to_hit    = (cnt_q == TO_LAST);
  assign gap_hit   = (cnt_q == GAP_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start_i && (frame_len_i != '0)) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done_i)   state_d = last_byte ? GAP : FETCH;
        else if (to_hit) state_d = IDLE;
      end
      GAP:     if (gap_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read strobe is registered on entry to FETCH so rd_data lands in LOAD.
  always_comb begin
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          if (frame_len_i != '0) begin
            len_d     = frame_len_i;
            idx_d     = '0;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: ;
      LOAD: begin
        tx_data_d  = rd_data_i;
        tx_start_d = 1'b1;
        cnt_d      = '0;
      end
      WAIT_TX: begin
        cnt_d = cnt_q + 1'b1;
        if (tx_done_i) begin
          if (last_byte) begin
            cnt_d = '0;
          end else begin
            idx_d     = idx_q + 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q + 1'b1;
          end
        end else if (to_hit) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_hit) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = rd_addr_q;
  assign tx_start_o   = tx_start_q;
  assign tx_data_o    = tx_data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_modbus_frame_tx_ctrl.sv
// Bench for modbus_frame_tx_ctrl: buffer model, UART stub and a scoreboard monitor.
module tb_modbus_frame_tx_ctrl;
  localparam int ADDR_W = 8;
  localparam int GAP    = 100;
  localparam int TO     = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic [ADDR_W-1:0] frame_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic              busy, frame_done, frame_err;

  modbus_frame_tx_ctrl #(.ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .frame_len_i(frame_len),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_done_i(tx_done),
    .busy_o(busy), .frame_done_o(frame_done), .frame_err_o(frame_err));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int len; bit err; int nbytes;} fexp_t;
  fexp_t      frameq[$];
  int         addrq[$];
  logic [7:0] byteq[$];
  logic [7:0] mem[256];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Buffer: data one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  // UART stub: random byte time, optional mute, optional stray done pulse.
  bit         mute = 1'b0;
  bit         stray_req = 1'b0;
  bit         stub_pend = 1'b0;
  int         stub_cnt = 0;
  logic [7:0] cap = 8'h00;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      stub_pend = 1'b0;
      tx_done   = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (stub_pend) begin
        if (stub_cnt == 0) begin
          tx_done   = 1'b1;
          stub_pend = 1'b0;
          chk("tx_data_hold", tx_data, cap);
        end else stub_cnt--;
      end
      if (tx_start && !mute) begin
        stub_pend = 1'b1;
        stub_cnt  = $urandom_range(1, 15);
        cap       = tx_data;
      end
      if (stray_req) begin
        tx_done   = 1'b1;
        stray_req = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  int    ends_seen = 0, starts_total = 0, nstarts = 0;
  int    last_start = 0, last_done = 0, fs_cyc = 0;
  bit    outstanding = 1'b0, busy_exp = 1'b0;
  fexp_t e;
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 1'b0;
      nstarts     = 0;
      busy_exp    = 1'b0;
    end else begin
      if (rd_en) begin
        if (addrq.size() == 0) chk("rd_en_unexpected", rd_addr, 999);
        else chk("rd_addr", rd_addr, addrq.pop_front());
      end
      if (tx_done && outstanding) begin
        last_done   = cyc;
        outstanding = 1'b0;
      end
      if (tx_start) begin
        if (byteq.size() == 0) chk("tx_start_unexpected", tx_data, 999);
        else chk("tx_data", tx_data, byteq.pop_front());
        nstarts++;
        starts_total++;
        last_start  = cyc;
        outstanding = 1'b1;
      end
      if (frame_done || frame_err) begin
        busy_exp = 1'b0;
        if (frameq.size() == 0) chk("end_unexpected", {frame_done, frame_err}, 0);
        else begin
          e = frameq.pop_front();
          chk("end_is_err", frame_err, e.err);
          chk("end_is_done", frame_done, !e.err);
          chk("tx_start_count", nstarts, e.nbytes);
          if (e.err)           chk("err_latency", cyc - last_start, TO);
          else if (e.len == 0) chk("empty_done_latency", cyc - fs_cyc, 1);
          else                 chk("gap_latency", cyc - last_done, GAP + 1);
        end
        nstarts = 0;
        ends_seen++;
      end
      chk("busy", busy, busy_exp);
      if (frame_start && !busy_exp) begin
        fs_cyc = cyc;
        if (frame_len != 0) busy_exp = 1'b1;
      end
    end
  end

  // Called right after a posedge; drives during the following cycle.
  task automatic start_frame(input int len, input bit mute_uart);
    mute = mute_uart;
    for (int i = 0; i < len; i++) begin
      if (!mute_uart || i == 0) begin
        addrq.push_back(i);
        byteq.push_back(mem[i]);
      end
    end
    frameq.push_back('{len: len, err: mute_uart, nbytes: (mute_uart ? 1 : len)});
    #1;
    frame_start = 1'b1;
    frame_len   = ADDR_W'(len);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    frame_len   = ADDR_W'($urandom);
  endtask

  task automatic wait_end(input int n_before, input int budget);
    int k = 0;
    while (ends_seen == n_before && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("frame_end_seen", ends_seen != n_before, 1);
  endtask

  task automatic send(input int len, input bit mute_uart);
    int n = ends_seen;
    start_frame(len, mute_uart);
    wait_end(n, len * 25 + GAP + TO + 50);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (starts_total < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("tx_start_seen", starts_total >= target, 1);
  endtask

  task automatic pulse_start(input int len);
    #1;
    frame_start = 1'b1;
    frame_len   = ADDR_W'(len);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, s0;
    rst = 1'b1;
    frame_start = 1'b0;
    frame_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rd_en, rd_addr, tx_start, tx_data, busy, frame_done, frame_err}, 0);
    rst = 1'b0;
    @(posedge clk);

    mem[0] = 8'hC2; mem[1] = 8'hB3; mem[2] = 8'hA4; mem[3] = 8'h95;
    send(4, 1'b0);
    send(0, 1'b0);
    mem[0] = 8'h01;
    send(1, 1'b0);
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    send(3, 1'b1);
    send(2, 1'b0);

    // Ignored frame_start during WAIT_TX and GAP, plus a stray tx_done in GAP.
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    n  = ends_seen;
    s0 = starts_total;
    fork
      begin
        start_frame(3, 1'b0);
        wait_end(n, 3 * 25 + GAP + 50);
      end
      begin
        wait_starts(s0 + 1, 200);
        repeat (2) @(posedge clk);
        pulse_start(5);
        wait_starts(s0 + 3, 200);
        for (int k = 0; k < 100 && outstanding; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        pulse_start(2);
        repeat (10) @(posedge clk);
        stray_req = 1'b1;
      end
    join
    @(posedge clk);

    // Asynchronous reset in the middle of the second byte of a 3-byte frame.
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    n  = ends_seen;
    s0 = starts_total;
    start_frame(3, 1'b0);
    wait_starts(s0 + 2, 200);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midframe_reset_outputs", {rd_en, rd_addr, tx_start, tx_data, busy, frame_done, frame_err}, 0);
    addrq.delete();
    byteq.delete();
    frameq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (GAP + 20) @(posedge clk);
    chk("no_end_after_reset", ends_seen, n);
    mem[0] = 8'h5A; mem[1] = 8'hA5;
    send(2, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(len, 1'b0);
    end

    repeat (5) @(posedge clk);
    chk("queues_drained", addrq.size() + byteq.size() + frameq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
